// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch sequencer: word width, FSM state
// encoding and the default memory timeout used when FETCH_TIMEOUT_EN is defined.
package fetch_pkg;
  localparam int WORD_W = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;
endpackage

// File: rtl/fetch_watchdog.sv
// Load/decrement down-counter; o_expired flags the decrement that reaches zero.
// Combinational expiry, so the owner can leave the wait state on that same edge.
module fetch_watchdog #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);
  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired = i_dec && (r_count <= W'(1));
endmodule

// File: rtl/fetch_unit.sv
// Fetch sequencer: IDLE->ISSUE->WAIT->HOLD, 3 cycles per word with zero-wait memory;
// stalls in HOLD until IR_TAKE, FLUSH aborts to ISSUE. FETCH_TIMEOUT_EN adds a WAIT watchdog.
module fetch_unit
  import fetch_pkg::*;
`ifdef FETCH_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT)
`endif
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WORD_W-1:0] PC_IN,
  output logic              PC_INC,
  output logic [WORD_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  input  logic [WORD_W-1:0] MEM_DATA,
  input  logic              MEM_READY,
  output logic [WORD_W-1:0] IR_OUT,
  output logic              IR_VALID,
  input  logic              IR_TAKE,
  input  logic              FLUSH,
`ifdef FETCH_TIMEOUT_EN
  output logic              FETCH_FAULT,
`endif
  input  logic              HALT
);
  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              w_capture;
  logic              w_load_addr;
  logic [WORD_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_ir_out;
  logic              r_ir_valid;
  logic              r_pc_inc;

`ifdef FETCH_TIMEOUT_EN
  logic w_expired;

  fetch_watchdog #(.W(WORD_W)) u_watchdog (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_load     (w_load_addr),
    .i_dec      ((r_state == S_WAIT) && !MEM_READY),
    .i_load_val (WORD_W'(TIMEOUT_CYCLES)),
    .o_expired  (w_expired)
  );

  assign FETCH_FAULT = (r_state == S_FAULT);
`endif

  // FLUSH outranks every other input outside IDLE; the PC is reloading, so refetch.
  always_comb begin
    w_next      = r_state;
    w_capture   = 1'b0;
    w_load_addr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!HALT) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (!FLUSH) begin
          w_next      = S_WAIT;
          w_load_addr = 1'b1;
        end
      end
      S_WAIT: begin
        if (FLUSH) begin
          w_next = S_ISSUE;
        end else if (MEM_READY) begin
          w_next    = S_HOLD;
          w_capture = 1'b1;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (w_expired) begin
          w_next = S_FAULT;
        end
`endif
      end
      S_HOLD: begin
        if (FLUSH) w_next = S_ISSUE;
        else if (IR_TAKE) w_next = HALT ? S_IDLE : S_ISSUE;
      end
      S_FAULT: begin
        if (FLUSH) w_next = S_ISSUE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_mem_addr <= '0;
      r_ir_out   <= '0;
      r_ir_valid <= 1'b0;
      r_pc_inc   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ir_valid <= (w_next == S_HOLD);
      r_pc_inc   <= w_capture;
      if (w_load_addr) r_mem_addr <= PC_IN;
      if (w_capture)   r_ir_out   <= MEM_DATA;
    end
  end

  // Decoded from state so RESET drops the request without waiting for a clock.
  assign MEM_RD   = (r_state == S_WAIT);
  assign MEM_ADDR = r_mem_addr;
  assign IR_OUT   = r_ir_out;
  assign IR_VALID = r_ir_valid;
  assign PC_INC   = r_pc_inc;
endmodule
